conv_feeder: RTL and testbench

CONV_FEEDER -- requirements
Module: conv_feeder

---
 rtl/conv_feeder.sv | 203 ++++++++++++++++++++
 tb/tb_conv_feeder.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_feeder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// conv_feeder
//
// Collects one KSIZE x KSIZE convolution window (pixel/weight pairs in raster
// order) into a local buffer, then streams it into an external MAC kernel:
// one accumulator-clear cycle, N tap cycles, DRAIN cycles waiting for the
// kernel pipeline to settle, and finally presents the accumulated sum as a
// single result beat with valid/ready handshake. Data words are never
// modified here; they pass through bit-exact.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   ld_valid   load pair valid
//   ld_ready   feeder can accept a load pair (registered)
//   ld_pixel   window pixel, raster order
//   ld_weight  matching kernel weight
//   k_clear    accumulator clear to the MAC kernel (registered)
//   k_pixel    pixel to the MAC kernel (registered)
//   k_weight   weight to the MAC kernel (registered)
//   k_result   accumulated sum returned by the MAC kernel
//   m_valid    result valid (registered)
//   m_ready    downstream accepts result
//   m_data     convolution result (registered)
//   busy       high whenever the feeder is not in its LOAD state
// ---------------------------------------------------------------------------
module conv_feeder #(
    parameter int WIDTH = 32,
    parameter int KSIZE = 3,
    parameter int DRAIN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [WIDTH-1:0] ld_pixel,
    input  logic [WIDTH-1:0] ld_weight,
    output logic             k_clear,
    output logic [WIDTH-1:0] k_pixel,
    output logic [WIDTH-1:0] k_weight,
    input  logic [WIDTH-1:0] k_result,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             busy
);

    localparam int N     = KSIZE * KSIZE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int DRN_W = $clog2(DRAIN + 1);

    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N - 1);
    localparam logic [DRN_W-1:0] LAST_DRN = DRN_W'(DRAIN - 1);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_CLEAR,
        ST_ISSUE,
        ST_DRAIN,
        ST_OUT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;
    logic [CNT_W-1:0] tap_q, tap_d;
    logic [DRN_W-1:0] drn_q, drn_d;

    logic             ld_ready_q, ld_ready_d;
    logic             k_clear_q, k_clear_d;
    logic [WIDTH-1:0] k_pixel_q, k_pixel_d;
    logic [WIDTH-1:0] k_weight_q, k_weight_d;
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;

    logic [WIDTH-1:0] pix_buf_q [N];
    logic [WIDTH-1:0] wt_buf_q  [N];

    logic             ld_fire;

    // A pair is taken only when the registered ready is already high, so the
    // first cycle after reset release (ready still low) never accepts.
    assign ld_fire = ld_valid && ld_ready_q && (state_q == ST_LOAD);

    // Window buffer. Deliberately not reset: a partially loaded window is
    // simply overwritten slot by slot by the next load after reset.
    always_ff @(posedge clk) begin
        if (ld_fire) begin
            pix_buf_q[ld_cnt_q] <= ld_pixel;
            wt_buf_q[ld_cnt_q]  <= ld_weight;
        end
    end

    // Next-state and next-output logic. All kernel/handshake outputs are
    // computed from the state being entered, so after the clock edge the
    // registered outputs line up with the state that is now current.
    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        tap_d      = tap_q;
        drn_d      = drn_q;
        m_data_d   = m_data_q;
        ld_ready_d = 1'b0;
        k_clear_d  = 1'b0;
        k_pixel_d  = '0;
        k_weight_d = '0;
        m_valid_d  = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (ld_fire) begin
                    if (ld_cnt_q == LAST_TAP) begin
                        ld_cnt_d = '0;
                        state_d  = ST_CLEAR;
                    end else begin
                        ld_cnt_d = ld_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_CLEAR: begin
                tap_d   = '0;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (tap_q == LAST_TAP) begin
                    tap_d   = '0;
                    drn_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    tap_d = tap_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                // The kernel result is valid during the last drain cycle;
                // capture it here so m_data is stable for the whole OUT phase.
                if (drn_q == LAST_DRN) begin
                    drn_d    = '0;
                    m_data_d = k_result;
                    state_d  = ST_OUT;
                end else begin
                    drn_d = drn_q + DRN_W'(1);
                end
            end
            ST_OUT: begin
                if (m_valid_q && m_ready) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        case (state_d)
            ST_LOAD:  ld_ready_d = 1'b1;
            ST_CLEAR: k_clear_d  = 1'b1;
            ST_ISSUE: begin
                k_pixel_d  = pix_buf_q[tap_d];
                k_weight_d = wt_buf_q[tap_d];
            end
            ST_OUT:   m_valid_d  = 1'b1;
            default: begin
            end
        endcase
    end

    // State, counters and registered outputs. Reset forces everything to
    // the idle LOAD picture with ready low until the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOAD;
            ld_cnt_q   <= '0;
            tap_q      <= '0;
            drn_q      <= '0;
            ld_ready_q <= 1'b0;
            k_clear_q  <= 1'b0;
            k_pixel_q  <= '0;
            k_weight_q <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            tap_q      <= tap_d;
            drn_q      <= drn_d;
            ld_ready_q <= ld_ready_d;
            k_clear_q  <= k_clear_d;
            k_pixel_q  <= k_pixel_d;
            k_weight_q <= k_weight_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
        end
    end

    assign ld_ready = ld_ready_q;
    assign k_clear  = k_clear_q;
    assign k_pixel  = k_pixel_q;
    assign k_weight = k_weight_q;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign busy     = (state_q != ST_LOAD);

endmodule

// File: tb/tb_conv_feeder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_conv_feeder
//
// Directed bench for conv_feeder with a behavioural single-precision MAC
// kernel of latency DRAIN attached to the k_* ports. Each scenario task
// drives its own stimulus and compares against hand-computed IEEE-754 words.
// ---------------------------------------------------------------------------
module tb_conv_feeder;

    localparam int WIDTH = 32;
    localparam int KSIZE = 3;
    localparam int DRAIN = 3;
    localparam int N     = KSIZE * KSIZE;

    localparam logic [31:0] F1  = 32'h3F800000;
    localparam logic [31:0] F2  = 32'h40000000;
    localparam logic [31:0] F3  = 32'h40400000;
    localparam logic [31:0] F9  = 32'h41100000;
    localparam logic [31:0] F18 = 32'h41900000;
    localparam logic [31:0] F45 = 32'h42340000;
    localparam logic [31:0] F54 = 32'h42580000;
    localparam logic [31:0] JUNK = 32'h42C80000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             ld_valid = 1'b0;
    logic             ld_ready;
    logic [WIDTH-1:0] ld_pixel = '0;
    logic [WIDTH-1:0] ld_weight = '0;
    logic             k_clear;
    logic [WIDTH-1:0] k_pixel;
    logic [WIDTH-1:0] k_weight;
    logic [WIDTH-1:0] k_result;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] m_data;
    logic             busy;

    int checks = 0;
    int failures = 0;

    logic [31:0] pix_vec [N];
    logic [31:0] wt_vec  [N];
    logic [31:0] iss_pix [N];
    logic [31:0] iss_wt  [N];

    conv_feeder #(.WIDTH(WIDTH), .KSIZE(KSIZE), .DRAIN(DRAIN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_pixel  (ld_pixel),
        .ld_weight (ld_weight),
        .k_clear   (k_clear),
        .k_pixel   (k_pixel),
        .k_weight  (k_weight),
        .k_result  (k_result),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Single-precision bits to real, enough for normal numbers and zero.
    function automatic real sp2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    // Real to single-precision bits (truncating), exact for the small
    // integers used in these scenarios.
    function automatic logic [31:0] r2sp(input real r);
        logic        s;
        int          e;
        real         m;
        logic [22:0] f;
        if (r == 0.0) return 32'd0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        f = 23'($rtoi((m - 1.0) * 8388608.0));
        return {s, 8'(e), f};
    endfunction

    // Behavioural MAC kernel: accumulate on every edge, clear on k_clear,
    // and deliver the sum through a DRAIN-deep pipeline.
    real         acc = 0.0;
    real         acc_next;
    logic [31:0] mac_pipe [DRAIN];

    always_comb acc_next = k_clear ? 0.0 : acc + sp2r(k_pixel) * sp2r(k_weight);

    always @(posedge clk) begin
        acc         <= acc_next;
        mac_pipe[0] <= r2sp(acc_next);
        for (int i = 1; i < DRAIN; i++) mac_pipe[i] <= mac_pipe[i-1];
    end

    assign k_result = mac_pipe[DRAIN-1];

    // Continuous protocol watch: ready and busy are mutually exclusive, and
    // kernel data is only nonzero while issuing taps.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (ld_ready && busy) begin
                failures++;
                $display("[TB] FAIL ready_busy_excl ld_ready=%0b busy=%0b required not both 1", ld_ready, busy);
            end
            if ((k_pixel != 0 || k_weight != 0) && (!busy || k_clear || m_valid)) begin
                failures++;
                $display("[TB] FAIL kdata_outside_issue k_pixel=%h k_weight=%h required 0 outside ISSUE", k_pixel, k_weight);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic fill_uniform(input logic [31:0] p, input logic [31:0] w);
        for (int i = 0; i < N; i++) begin
            pix_vec[i] = p;
            wt_vec[i]  = w;
        end
    endtask

    task automatic load_window(input bit toggle, output int accepts, output bit early_busy);
        int i;
        int n;
        bit ph;
        i = 0; n = 0; ph = 1'b0; early_busy = 1'b0;
        while (i < N && n < 200) begin
            @(negedge clk);
            n++;
            if (busy) early_busy = 1'b1;
            if (toggle && ph) begin
                ld_valid = 1'b0;
            end else begin
                ld_valid  = 1'b1;
                ld_pixel  = pix_vec[i];
                ld_weight = wt_vec[i];
                if (ld_ready) i++;
            end
            ph = ~ph;
        end
        @(negedge clk);
        ld_valid = 1'b0;
        accepts = i;
    endtask

    task automatic observe_window(input int hold, input bit junk,
                                  output int clears, output int latency,
                                  output logic [31:0] res, output int valid_cycles,
                                  output int unstable, output bit post_ready,
                                  output bit timeout);
        int n;
        int tap;
        int clear_at;
        clears = 0; latency = -1; res = '0; valid_cycles = 0; unstable = 0;
        post_ready = 1'b0; timeout = 1'b0; tap = N; n = 0; clear_at = 0;
        m_ready = (hold == 0);
        if (junk) begin
            ld_valid  = 1'b1;
            ld_pixel  = JUNK;
            ld_weight = JUNK;
        end
        while (!m_valid && n < 200) begin
            if (k_clear) begin
                clears++;
                tap = 0;
                clear_at = n;
            end else if (tap < N) begin
                iss_pix[tap] = k_pixel;
                iss_wt[tap]  = k_weight;
                tap++;
            end
            @(negedge clk);
            n++;
        end
        ld_valid = 1'b0;
        if (!m_valid) begin
            timeout = 1'b1;
            return;
        end
        latency = n - clear_at;
        res = m_data;
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                if (!m_valid || m_data !== res || ld_ready || !busy) unstable++;
                @(negedge clk);
            end
            m_ready = 1'b1;
            @(negedge clk);
            valid_cycles = hold;
        end else begin
            while (m_valid && valid_cycles < 5) begin
                valid_cycles++;
                @(negedge clk);
            end
        end
        post_ready = ld_ready && !m_valid && !busy;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({ld_ready, busy, k_clear, m_valid} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_ctrl {ld_ready,busy,k_clear,m_valid}=%b required 0000", {ld_ready, busy, k_clear, m_valid});
        end
        checks++;
        if (k_pixel !== 32'd0 || k_weight !== 32'd0 || m_data !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_data k_pixel=%h k_weight=%h m_data=%h required 0", k_pixel, k_weight, m_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ld_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release ld_ready=%b busy=%b required 1/0", ld_ready, busy);
        end
    endtask

    task automatic test_basic();
        int acc_n; bit eb; int clr; int lat; logic [31:0] r; int vc; int us; bit pr; bit to; int bad;
        fill_uniform(F1, F2);
        load_window(1'b0, acc_n, eb);
        observe_window(0, 1'b0, clr, lat, r, vc, us, pr, to);
        checks++;
        if (to) begin failures++; $display("[TB] FAIL basic_timeout m_valid=0 required 1 within budget"); end
        checks++;
        if (clr != 1) begin failures++; $display("[TB] FAIL basic_clears got=%0d required=1", clr); end
        checks++;
        if (lat != 1 + N + DRAIN) begin failures++; $display("[TB] FAIL basic_latency got=%0d required=%0d", lat, 1 + N + DRAIN); end
        checks++;
        if (r !== F18) begin failures++; $display("[TB] FAIL basic_result got=%h required=%h", r, F18); end
        checks++;
        if (vc != 1) begin failures++; $display("[TB] FAIL basic_valid_cycles got=%0d required=1", vc); end
        checks++;
        if (!pr) begin failures++; $display("[TB] FAIL basic_back_to_load ld_ready=%b m_valid=%b required 1/0", ld_ready, m_valid); end
        bad = 0;
        for (int i = 0; i < N; i++) if (iss_pix[i] !== F1 || iss_wt[i] !== F2) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("[TB] FAIL basic_issue_taps bad_taps=%0d required=0", bad); end
    endtask

    task automatic test_ordered_taps();
        int acc_n; bit eb; int clr; int lat; logic [31:0] r; int vc; int us; bit pr; bit to;
        for (int i = 0; i < N; i++) begin
            pix_vec[i] = r2sp(real'(i + 1));
            wt_vec[i]  = F1;
        end
        load_window(1'b0, acc_n, eb);
        observe_window(0, 1'b1, clr, lat, r, vc, us, pr, to);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (iss_pix[i] !== pix_vec[i]) begin
                failures++;
                $display("[TB] FAIL ordered_tap%0d got=%h required=%h", i, iss_pix[i], pix_vec[i]);
            end
        end
        checks++;
        if (to || r !== F45) begin failures++; $display("[TB] FAIL ordered_result got=%h required=%h", r, F45); end
    endtask

    task automatic test_toggle_load();
        int acc_n; bit eb; int clr; int lat; logic [31:0] r; int vc; int us; bit pr; bit to;
        fill_uniform(F1, F2);
        load_window(1'b1, acc_n, eb);
        checks++;
        if (acc_n != N) begin failures++; $display("[TB] FAIL toggle_accepts got=%0d required=%0d", acc_n, N); end
        checks++;
        if (eb) begin failures++; $display("[TB] FAIL toggle_early_busy busy=1 required 0 before last accept"); end
        observe_window(0, 1'b0, clr, lat, r, vc, us, pr, to);
        checks++;
        if (clr != 1) begin failures++; $display("[TB] FAIL toggle_clears got=%0d required=1", clr); end
        checks++;
        if (to || r !== F18) begin failures++; $display("[TB] FAIL toggle_result got=%h required=%h", r, F18); end
    endtask

    task automatic test_backpressure();
        int acc_n; bit eb; int clr; int lat; logic [31:0] r; int vc; int us; bit pr; bit to;
        fill_uniform(F2, F3);
        load_window(1'b0, acc_n, eb);
        observe_window(20, 1'b0, clr, lat, r, vc, us, pr, to);
        checks++;
        if (to || r !== F54) begin failures++; $display("[TB] FAIL bp_result got=%h required=%h", r, F54); end
        checks++;
        if (us != 0) begin failures++; $display("[TB] FAIL bp_hold unstable_cycles=%0d required=0", us); end
        checks++;
        if (!pr) begin failures++; $display("[TB] FAIL bp_release ld_ready=%b m_valid=%b required 1/0", ld_ready, m_valid); end
    endtask

    task automatic test_back_to_back();
        int acc_n; bit eb; int clr; int lat; logic [31:0] r; int vc; int us; bit pr; bit to;
        fill_uniform(F1, F1);
        load_window(1'b0, acc_n, eb);
        observe_window(0, 1'b0, clr, lat, r, vc, us, pr, to);
        checks++;
        if (to || r !== F9) begin failures++; $display("[TB] FAIL b2b_first got=%h required=%h", r, F9); end
        fill_uniform(F2, F3);
        load_window(1'b0, acc_n, eb);
        observe_window(0, 1'b0, clr, lat, r, vc, us, pr, to);
        checks++;
        if (to || r !== F54) begin failures++; $display("[TB] FAIL b2b_second got=%h required=%h", r, F54); end
    endtask

    task automatic test_reset_mid_issue();
        int acc_n; bit eb; int clr; int lat; logic [31:0] r; int vc; int us; bit pr; bit to; int n;
        for (int i = 0; i < N; i++) begin
            pix_vec[i] = r2sp(real'(i + 1));
            wt_vec[i]  = F2;
        end
        load_window(1'b0, acc_n, eb);
        n = 0;
        while (!k_clear && n < 50) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        checks++;
        if (k_pixel !== pix_vec[4]) begin failures++; $display("[TB] FAIL mid_tap4 got=%h required=%h", k_pixel, pix_vec[4]); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({k_clear, m_valid, busy, ld_ready} !== 4'b0000 || k_pixel !== 32'd0 || k_weight !== 32'd0 || m_data !== 32'd0) begin
            failures++;
            $display("[TB] FAIL mid_reset_outputs ctrl=%b k_pixel=%h k_weight=%h m_data=%h required all 0",
                     {k_clear, m_valid, busy, ld_ready}, k_pixel, k_weight, m_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ld_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_release ld_ready=%b required 1", ld_ready); end
        fill_uniform(F1, F2);
        load_window(1'b0, acc_n, eb);
        observe_window(0, 1'b0, clr, lat, r, vc, us, pr, to);
        checks++;
        if (to || clr != 1 || r !== F18) begin
            failures++;
            $display("[TB] FAIL mid_next_window result=%h clears=%0d required=%h/1", r, clr, F18);
        end
    endtask

    initial begin
        $display("[TB] conv_feeder bench start");
        test_reset();
        test_basic();
        test_ordered_taps();
        test_toggle_load();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_issue();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
